// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and address-width helper for regfile_mp
package regfile_pkg;
  typedef enum logic [0:0] {SWEEP = 1'b0, IDLE = 1'b1} state_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with issue set, writeback clear and forwarding-aware lookup
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DEPTH  = 32,
  parameter int AW     = addr_w(DEPTH),
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         set,
  input  logic [AW-1:0]                set_addr,
  input  logic [NWRITE-1:0]            wvalid,
  input  logic [NWRITE-1:0][AW-1:0]    waddr,
  input  logic [NREAD-1:0][AW-1:0]     raddr,
  output logic [NREAD-1:0]             rbusy
);
  logic [DEPTH-1:0] busy_q, busy_d;
  // a new producer supersedes the retiring one, so set follows clear
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWRITE; w++)
      if (wvalid[w]) busy_d[waddr[w]] = 1'b0;
    if (set) busy_d[set_addr] = 1'b1;
    if (clr) busy_d = '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_q <= '0;
    else busy_q <= busy_d;
  always_comb begin
    rbusy = '0;
    for (int r = 0; r < NREAD; r++) begin
      rbusy[r] = en & busy_q[raddr[r]];
      for (int w = 0; w < NWRITE; w++)
        if (wvalid[w] && waddr[w] == raddr[r]) rbusy[r] = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write forwarding, clear sweep and hazard scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = addr_w(DEPTH),
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE-1:0][AW-1:0]    waddr,
  input  logic [NWRITE-1:0][XLEN-1:0]  wdata,
  input  logic [NREAD-1:0][AW-1:0]     raddr,
  output logic [NREAD-1:0][XLEN-1:0]   rdata,
  output logic [NREAD-1:0]             rbusy,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  input  logic                         clr_req,
  output logic                         ready
);
  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [NWRITE-1:0] wvalid;
  logic             issue_v;
  assign ready   = state_q == IDLE;
  assign issue_v = ready && issue_en && !(ZERO_REG && issue_addr == '0);
  always_comb begin
    wvalid = '0;
    for (int w = 0; w < NWRITE; w++)
      wvalid[w] = ready && wen[w] && !(ZERO_REG && waddr[w] == '0);
  end
  always_comb begin
    state_d = ready ? (clr_req ? SWEEP : IDLE) : (idx_q == AW'(DEPTH - 1) ? IDLE : SWEEP);
    idx_d   = ready ? '0 : idx_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  // later ports overwrite earlier ones, giving the highest-index port priority
  always_ff @(posedge clk)
    if (!ready) mem_q[idx_q] <= '0;
    else
      for (int w = 0; w < NWRITE; w++)
        if (wvalid[w]) mem_q[waddr[w]] <= wdata[w];
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NREAD; r++) begin
      rdata[r] = mem_q[raddr[r]];
      for (int w = 0; w < NWRITE; w++)
        if (wvalid[w] && waddr[w] == raddr[r]) rdata[r] = wdata[w];
      if (!ready || (ZERO_REG && raddr[r] == '0)) rdata[r] = '0;
    end
  end
  regfile_scoreboard #(.DEPTH(DEPTH), .AW(AW), .NREAD(NREAD), .NWRITE(NWRITE)) u_sb (
    .clk(clk), .rst(rst), .en(ready), .clr(ready && clr_req), .set(issue_v),
    .set_addr(issue_addr), .wvalid(wvalid), .waddr(waddr), .raddr(raddr), .rbusy(rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
  localparam int XLEN = 32, DEPTH = 32, AW = 5, NREAD = 2, NWRITE = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [NWRITE-1:0] wen;
  logic [NWRITE-1:0][AW-1:0] waddr;
  logic [NWRITE-1:0][XLEN-1:0] wdata;
  logic [NREAD-1:0][AW-1:0] raddr;
  logic [NREAD-1:0][XLEN-1:0] rdata;
  logic [NREAD-1:0] rbusy;
  logic issue_en, clr_req, ready;
  logic [AW-1:0] issue_addr;
  int n_cmp = 0, n_bad = 0;
  logic [XLEN-1:0] m [DEPTH];
  bit b [DEPTH];
  int left;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
    .rbusy(rbusy), .issue_en(issue_en), .issue_addr(issue_addr), .clr_req(clr_req), .ready(ready)
  );

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (!rst || left != 0 || a == 0) return '0;
    v = m[a];
    for (int w = 0; w < NWRITE; w++) if (wen[w] && waddr[w] == a) v = wdata[w];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    bit hit = 0;
    if (!rst || left != 0 || a == 0) return 0;
    for (int w = 0; w < NWRITE; w++) if (wen[w] && waddr[w] == a) hit = 1;
    return b[a] && !hit;
  endfunction

  task automatic wipe();
    left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin m[i] = '0; b[i] = 0; end
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; issue_en = 0; issue_addr = '0; clr_req = 0;
  endtask

  // advance one clock edge, applying the inputs present at that edge to the model
  task automatic tick();
    @(posedge clk);
    if (!rst) wipe();
    else if (left > 0) left--;
    else begin
      for (int w = 0; w < NWRITE; w++)
        if (wen[w] && waddr[w] != 0) begin m[waddr[w]] = wdata[w]; b[waddr[w]] = 0; end
      if (issue_en && issue_addr != 0) b[issue_addr] = 1;
      if (clr_req) wipe();
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); raddr = '0; rst = 0; wipe();
    repeat (2) tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    rst = 1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      n_cmp++; if (ready !== (k >= DEPTH)) begin n_bad++; $display("FAIL reset_ready_k%0d got=%b want=%b", k, ready, k >= DEPTH); end
    end
    for (int a = 0; a < DEPTH; a++) begin
      wen = 2'b01; waddr[0] = AW'(a); wdata[0] = $urandom | 32'h1; tick();
    end
    idle(); raddr[0] = 5'd9; raddr[1] = 5'd17;
    rst = 0; #1;
    n_cmp++; if (ready !== 1'b0 || rdata !== '0) begin n_bad++; $display("FAIL reset_async got ready=%b rdata=%h want 0/0", ready, rdata); end
    wipe(); tick(); rst = 1;
    repeat (DEPTH) tick();
    for (int a = 0; a < DEPTH; a++) begin
      raddr[0] = AW'(a); raddr[1] = AW'(DEPTH - 1 - a); #1;
      n_cmp++; if (rdata !== '0 || ready !== 1'b1) begin n_bad++; $display("FAIL reset_clean a=%0d got=%h ready=%b want 0/1", a, rdata, ready); end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      wen = NWRITE'($urandom); issue_en = $urandom_range(0, 1); clr_req = 0;
      for (int w = 0; w < NWRITE; w++) begin waddr[w] = AW'($urandom_range(0, 7)); wdata[w] = $urandom; end
      for (int r = 0; r < NREAD; r++) raddr[r] = AW'($urandom_range(0, 7));
      issue_addr = AW'($urandom_range(0, 7));
      #1;
      for (int r = 0; r < NREAD; r++) begin
        n_cmp++; if (rdata[r] !== exp_rd(raddr[r])) begin n_bad++; $display("FAIL rand_rdata%0d a=%0d got=%h want=%h", r, raddr[r], rdata[r], exp_rd(raddr[r])); end
        n_cmp++; if (rbusy[r] !== exp_busy(raddr[r])) begin n_bad++; $display("FAIL rand_rbusy%0d a=%0d got=%b want=%b", r, raddr[r], rbusy[r], exp_busy(raddr[r])); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_multi_write();
    wen = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5; wdata[0] = 32'hAAAA_0000; wdata[1] = 32'h0000_5555; raddr[0] = 5'd5; #1;
    n_cmp++; if (rdata[0] !== 32'h0000_5555) begin n_bad++; $display("FAIL multi_fwd got=%h want=00005555", rdata[0]); end
    tick(); idle(); #1;
    n_cmp++; if (rdata[0] !== 32'h0000_5555) begin n_bad++; $display("FAIL multi_store got=%h want=00005555", rdata[0]); end
  endtask

  task automatic test_zero_reg();
    wen = 2'b01; waddr[0] = '0; wdata[0] = 32'hDEAD_BEEF; issue_en = 1; issue_addr = '0; raddr[0] = '0; #1;
    n_cmp++; if (rdata[0] !== '0) begin n_bad++; $display("FAIL zero_fwd got=%h want=0", rdata[0]); end
    tick(); idle(); #1;
    n_cmp++; if (rdata[0] !== '0 || rbusy[0] !== 1'b0) begin n_bad++; $display("FAIL zero_after got=%h busy=%b want 0/0", rdata[0], rbusy[0]); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_addr = 5'd7; raddr[0] = 5'd7; #1;
    n_cmp++; if (rbusy[0] !== 1'b0) begin n_bad++; $display("FAIL sb_issue_same got=%b want=0", rbusy[0]); end
    tick(); idle(); #1;
    n_cmp++; if (rbusy[0] !== 1'b1) begin n_bad++; $display("FAIL sb_issue got=%b want=1", rbusy[0]); end
    wen = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h1234; #1;
    n_cmp++; if (rbusy[0] !== 1'b0 || rdata[0] !== 32'h1234) begin n_bad++; $display("FAIL sb_wb got busy=%b data=%h want 0/1234", rbusy[0], rdata[0]); end
    tick(); idle(); #1;
    n_cmp++; if (rbusy[0] !== 1'b0 || rdata[0] !== 32'h1234) begin n_bad++; $display("FAIL sb_wb_after got busy=%b data=%h want 0/1234", rbusy[0], rdata[0]); end
    wen = 2'b10; waddr[1] = 5'd7; wdata[1] = 32'h77; issue_en = 1; issue_addr = 5'd7;
    tick(); idle(); #1;
    n_cmp++; if (rbusy[0] !== 1'b1 || rdata[0] !== 32'h77) begin n_bad++; $display("FAIL sb_set_wins got busy=%b data=%h want 1/77", rbusy[0], rdata[0]); end
  endtask

  task automatic test_clear();
    for (int a = 0; a < DEPTH; a++) begin wen = 2'b01; waddr[0] = AW'(a); wdata[0] = 32'hFFFF_FFFF; tick(); end
    idle(); clr_req = 1; tick(); idle();
    for (int k = 0; k < DEPTH; k++) begin
      wen = 2'b11; issue_en = 1; issue_addr = AW'($urandom_range(1, DEPTH - 1));
      for (int w = 0; w < NWRITE; w++) begin waddr[w] = AW'($urandom_range(1, DEPTH - 1)); wdata[w] = $urandom; end
      raddr[0] = waddr[0]; raddr[1] = AW'($urandom_range(1, DEPTH - 1)); #1;
      n_cmp++; if (ready !== 1'b0 || rdata !== '0 || rbusy !== '0) begin n_bad++; $display("FAIL clr_sweep k=%0d ready=%b rdata=%h rbusy=%b want 0/0/0", k, ready, rdata, rbusy); end
      tick();
    end
    idle();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready got=%b want=1", ready); end
    for (int a = 0; a < DEPTH; a++) begin
      raddr[0] = AW'(a); raddr[1] = AW'(a); #1;
      n_cmp++; if (rdata !== '0 || rbusy !== '0) begin n_bad++; $display("FAIL clr_clean a=%0d got=%h busy=%b want 0/0", a, rdata, rbusy); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    idle(); clr_req = 1; tick(); idle();
    repeat (10) tick();
    rst = 0; #1;
    n_cmp++; if (ready !== 1'b0 || rdata !== '0) begin n_bad++; $display("FAIL mid_rst ready=%b rdata=%h want 0/0", ready, rdata); end
    wipe(); repeat (3) tick();
    rst = 1; cnt = 0;
    while (!ready && cnt < 100) begin tick(); cnt++; end
    n_cmp++; if (cnt !== DEPTH) begin n_bad++; $display("FAIL mid_rst_len got=%0d want=%0d", cnt, DEPTH); end
  endtask

  initial begin
    idle(); raddr = '0;
    test_reset();
    test_random(200);
    test_multi_write();
    test_zero_reg();
    test_scoreboard();
    test_random(200);
    test_clear();
    test_random(100);
    test_reset_mid_sweep();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next-generation RV32I pipeline: NREAD asynchronous read ports, NWRITE write ports, same-cycle write forwarding, hardwired-zero entry 0, a hardware clear sequencer, and a pending-write scoreboard for hazard detection. It sits between decode (reads, issue) and writeback (writes). It replaces the flat reset loop with a one-entry-per-cycle sweep, and it exposes per-port busy status to the hazard unit.

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of entries (power of two, ≥2); AW = $clog2(DEPTH)
- NREAD, 2, number of read ports (≥1)
- NWRITE, 1, number of write ports (≥1)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes and issues
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wen  in  NWRITE  per-port write enable
- waddr  in  NWRITE×AW  per-port write address
- wdata  in  NWRITE×XLEN  per-port write data
- raddr  in  NREAD×AW  per-port read address
- rdata  out  NREAD×XLEN  per-port read data (combinational)
- rbusy  out  NREAD  entry at raddr[i] has an outstanding producer
- issue_en  in  1  mark issue_addr as pending
- issue_addr  in  AW  destination of the issued instruction
- clr_req  in  1  start a clear sweep (ignored unless ready)
- ready  out  1  file is usable; 0 during reset and sweep

## Operation
- FSM states: SWEEP, IDLE. Reset asserted: state=SWEEP, sweep index=0, all busy bits=0, ready=0. Storage is not reset.
- SWEEP: each cycle, write 0 to entry [index], then increment the index. After entry DEPTH-1 is written, go to IDLE. ready=1 from the following cycle.
- IDLE with clr_req=1: clear all busy bits, set index=0, enter SWEEP. Requests already in SWEEP have no effect.
- While ready=0: wen and issue_en are ignored, rdata=0, and rbusy=0.
- Write: in IDLE, each port with wen=1 writes wdata to waddr at the clock edge. Writes to entry 0 are dropped when ZERO_REG=1.
- Multiple ports writing the same address in one cycle: the highest-index port wins.
- Read: rdata[i] returns the winning same-cycle write data when a valid write targets raddr[i]; otherwise it returns the stored value. Entry 0 returns 0 when ZERO_REG=1.
- Scoreboard: issue_en sets busy[issue_addr]. Any valid write clears busy[waddr]. If an issue and a write hit the same address in the same cycle, set wins, because the new producer supersedes the old one. Issues to entry 0 are ignored when ZERO_REG=1.
- rbusy[i] = busy[raddr[i]] AND NOT (valid write to raddr[i] this cycle). This matches forwarding. A same-cycle issue is not visible until the next cycle.

## Timing
- Read latency 0: combinational from raddr, wen, waddr and wdata.
- Write, busy-set and busy-clear take effect at the next rising edge.
- Sweep length is DEPTH cycles. ready rises DEPTH cycles after the first clk edge with rst high, or DEPTH cycles after the edge that accepts clr_req.
- Reset mid-sweep or mid-operation: return immediately to SWEEP with index 0 and busy cleared. rdata is 0 while rst is low.
- Reset values: ready=0, rbusy=0, rdata=0.

## Structure
- Package regfile_pkg holds the FSM state enum (SWEEP, IDLE) and the helper function that computes AW.
- Sub-module regfile_scoreboard holds the DEPTH-bit busy vector with issue set, NWRITE-port clear, sweep clear, and NREAD busy lookups.
- The top level holds storage, write arbitration, forwarding muxes, the sweep FSM and the index counter.

## Test plan
- Reset, then wait: ready=0 for 32 cycles and 1 on cycle 33. Every raddr then reads 0, including entries written with garbage before reset.
- NWRITE=2, both ports write addr 5 (0xAAAA_0000 on port 0, 0x0000_5555 on port 1) in one cycle: rdata at addr 5 is 0x0000_5555 combinationally in that cycle and after the edge.
- Write to addr 0 with 0xDEAD_BEEF, ZERO_REG=1: rdata=0, and issue to addr 0 leaves rbusy=0.
- Issue addr 7 → rbusy=1 next cycle. A writeback to 7 with 0x1234 gives rbusy=0 and rdata=0x1234 in the same cycle. Issue and write to 7 in the same cycle → rbusy=1 afterwards.
- clr_req after writing 0xFFFF_FFFF to all entries: ready=0 for DEPTH cycles, writes are ignored during the sweep, then all entries read 0.
- Drop rst at sweep index 10: ready stays 0, and the sweep restarts from 0 after release, taking a full DEPTH cycles.
